seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for the calculator's NDIG-digit 7-segment display.
//  - Accepts a frame of digit codes through a valid/ready write port.
//  - Applies leading-zero suppression, minus-sign placement and decimal points.
//  - Steps through the digits, driving a 6-bit code (num) to the shared SEG decoder and a one-hot digit select.
//  - Blanks digits through dig_sel only; decoder code default decodes to all segments lit.

---
 rtl/seg_scan_ctrl.sv | 113 +++++++++++
 tb/tb_seg_scan_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 7-segment scan with frame double-buffering, zero suppression and minus placement
module seg_scan_ctrl #(
   parameter int NDIG           = 4,
   parameter int SCAN_DIV       = 50000,
   parameter int BLANK_CYC      = 16,
   parameter bit DIG_ACTIVE_LOW = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [6*NDIG-1:0] wr_codes,
   input  logic [NDIG-1:0]   wr_dp,
   input  logic              wr_neg,
   input  logic              lz_sup,
   output logic [5:0]        num,
   output logic [NDIG-1:0]   dig_sel,
   output logic              frame_tick,
   output logic              ovf
);
   localparam int IW = $clog2(NDIG);
   localparam int CW = $clog2(SCAN_DIV);
   typedef enum logic {BLANK, SHOW} state_t;
   state_t state;
   logic [IW-1:0] idx, nidx, msd, pos;
   logic [CW-1:0] cnt;
   logic [NDIG-1:0] sel;
   logic [NDIG-1:0][5:0] enc_code, pend_code, act_code;
   logic [NDIG-1:0] enc_blank, pend_blank, act_blank;
   logic enc_ovf, pend_ovf, act_ovf, pend_full, sup, found, lead, xfer;
   logic [5:0] v;
   assign wr_ready = !pend_full;
   assign ovf = act_ovf;
   assign xfer = frame_tick && pend_full;
   assign nidx = (idx == IW'(NDIG - 1)) ? '0 : idx + 1'b1;
   assign dig_sel = DIG_ACTIVE_LOW ? ~sel : sel;
   // Encode the incoming frame: code+dp, blanking, leading-zero suppression from the top, then the minus sign
   always_comb begin
      enc_code = '0;
      enc_blank = '0;
      enc_ovf = 1'b0;
      sup = lz_sup;
      found = 1'b0;
      msd = '0;
      v = '0;
      lead = 1'b0;
      for (int i = NDIG - 1; i >= 0; i--) begin
         v = wr_codes[6*i +: 6];
         lead = sup && v == 6'd0 && !wr_dp[i] && i != 0;
         sup = lead;
         enc_code[i] = v + (wr_dp[i] ? 6'd16 : 6'd0);
         enc_blank[i] = lead || v > 6'd9;
         if (!enc_blank[i] && !found) begin
            found = 1'b1;
            msd = IW'(i);
         end
      end
      pos = (msd == IW'(NDIG - 1) || !found) ? msd : msd + 1'b1;
      if (wr_neg) begin
         enc_code[pos] = 6'd10;
         enc_blank[pos] = 1'b0;
         enc_ovf = found && msd == IW'(NDIG - 1);
      end
   end
   // Pending buffer takes one frame per handshake and drains into the active buffer only at the frame boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_code <= '0;
         pend_blank <= '1;
         pend_ovf <= 1'b0;
         pend_full <= 1'b0;
         act_code <= '0;
         act_blank <= '1;
         act_ovf <= 1'b0;
      end else if (xfer) begin
         act_code <= pend_code;
         act_blank <= pend_blank;
         act_ovf <= pend_ovf;
         pend_full <= 1'b0;
      end else if (wr_valid && !pend_full) begin
         pend_code <= enc_code;
         pend_blank <= enc_blank;
         pend_ovf <= enc_ovf;
         pend_full <= 1'b1;
      end
   end
   // Slot sequencer: dead time then show; num is loaded on slot entry, taking the fresh frame at the wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= BLANK;
         idx <= '0;
         cnt <= '0;
         num <= '0;
         sel <= '0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= idx == IW'(NDIG - 1) && cnt == CW'(SCAN_DIV - 2);
         if (cnt == CW'(SCAN_DIV - 1)) begin
            cnt <= '0;
            idx <= nidx;
            state <= BLANK;
            sel <= '0;
            num <= xfer ? pend_code[nidx] : act_code[nidx];
         end else begin
            cnt <= cnt + 1'b1;
            if (state == BLANK && cnt == CW'(BLANK_CYC - 1)) begin
               state <= SHOW;
               sel <= act_blank[idx] ? '0 : NDIG'(1) << idx;
            end
         end
      end
   end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: random and directed checks of seg_scan_ctrl against a frame-level display model
module tb_seg_scan_ctrl;
   localparam int ND = 4, SD = 8, BC = 2;
   typedef struct packed {
      logic [3:0][5:0] code;
      logic [3:0]      blk;
      logic            ovf;
   } frame_t;
   localparam frame_t RST = '{code: '0, blk: 4'b1111, ovf: 1'b0};
   logic clk = 1'b0, rst_n = 1'b0, wr_valid = 1'b0, wr_neg = 1'b0, lz_sup = 1'b0;
   logic [23:0] wr_codes = '0;
   logic [3:0] wr_dp = '0, dig_sel;
   logic wr_ready, frame_tick, ovf;
   logic [5:0] num;
   int checks = 0, errors = 0;
   frame_t act, pend;
   logic pfull;
   int k;
   seg_scan_ctrl #(.NDIG(ND), .SCAN_DIV(SD), .BLANK_CYC(BC), .DIG_ACTIVE_LOW(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_codes(wr_codes),
      .wr_dp(wr_dp), .wr_neg(wr_neg), .lz_sup(lz_sup), .num(num), .dig_sel(dig_sel),
      .frame_tick(frame_tick), .ovf(ovf)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, want);
      end
   endtask
   // Display a frame as the spec describes it: suppress above the highest non-zero/dp digit, minus left of top shown digit
   function automatic frame_t encode(input logic [23:0] c, input logic [3:0] dp, input logic neg, input logic lz);
      frame_t f;
      int top, msd, v, p;
      top = 0;
      msd = -1;
      for (int i = 0; i < ND; i++) if (c[6*i +: 6] != 0 || dp[i]) top = i;
      for (int i = 0; i < ND; i++) begin
         v = int'(c[6*i +: 6]);
         f.code[i] = 6'((v + 16 * int'(dp[i])) % 64);
         f.blk[i] = v > 9 || (lz && i > top);
         if (!f.blk[i]) msd = i;
      end
      f.ovf = 1'b0;
      if (neg) begin
         p = msd < 0 ? 0 : (msd == ND - 1 ? ND - 1 : msd + 1);
         f.ovf = msd == ND - 1;
         f.code[p] = 6'd10;
         f.blk[p] = 1'b0;
      end
      return f;
   endfunction
   // Per-cycle comparison against the model; k counts clocks since reset release
   initial begin
      int idx, ph;
      logic acc;
      logic [3:0] es;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            act = RST;
            pend = RST;
            pfull = 1'b0;
            k = 0;
            chk("rst_dig_sel", dig_sel, 4'b1111);
            chk("rst_num", num, 0);
            chk("rst_wr_ready", wr_ready, 1);
         end else begin
            idx = (k / SD) % ND;
            ph = k % SD;
            es = (ph >= BC && !act.blk[idx]) ? ~(4'b0001 << idx) : 4'b1111;
            chk("m_dig_sel", dig_sel, es);
            chk("m_num", num, act.code[idx]);
            chk("m_frame_tick", frame_tick, k % (SD * ND) == SD * ND - 1);
            chk("m_ovf", ovf, act.ovf);
            chk("m_wr_ready", wr_ready, !pfull);
            acc = wr_valid && !pfull;
            if (k % (SD * ND) == SD * ND - 1 && pfull) begin
               act = pend;
               pfull = 1'b0;
            end
            if (acc) begin
               pend = encode(wr_codes, wr_dp, wr_neg, lz_sup);
               pfull = 1'b1;
            end
            k++;
         end
      end
   end
   task automatic drive(input logic v, input logic [23:0] c, input logic [3:0] d, input logic n, input logic l);
      wr_valid = v;
      wr_codes = c;
      wr_dp = d;
      wr_neg = n;
      lz_sup = l;
   endtask
   task automatic do_write(input logic [23:0] c, input logic [3:0] d, input logic n, input logic l);
      int t = 0;
      @(posedge clk); #2;
      while (!wr_ready && t < 100) begin
         @(posedge clk); #2;
         t++;
      end
      if (t >= 100) chk("wr_ready_timeout", wr_ready, 1);
      drive(1'b1, c, d, n, l);
      @(posedge clk); #2;
      wr_valid = 1'b0;
   endtask
   task automatic wait_xfer();
      int t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!wr_ready && t < 100);
      if (t >= 100) chk("xfer_timeout", wr_ready, 1);
   endtask
   task automatic wait_ft();
      int t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!frame_tick && t < 100);
      if (t >= 100) chk("frame_tick_timeout", frame_tick, 1);
   endtask
   // Called at the first negedge of a frame; samples the middle of each slot's show window
   task automatic check_frame(input string tag, input logic [3:0][5:0] en, input logic [3:0][3:0] es, input logic eo);
      for (int s = 0; s < ND; s++) begin
         repeat (s == 0 ? 5 : SD) @(negedge clk);
         chk($sformatf("%s_slot%0d_num", tag, s), num, en[s]);
         chk($sformatf("%s_slot%0d_sel", tag, s), dig_sel, es[s]);
         chk($sformatf("%s_slot%0d_ovf", tag, s), ovf, eo);
      end
   endtask
   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
   initial begin
      logic [23:0] rc;
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      do_write({6'd0, 6'd0, 6'd4, 6'd2}, 4'b0000, 1'b0, 1'b1);
      wait_xfer();
      check_frame("lz", {6'd0, 6'd0, 6'd4, 6'd2}, {4'b1111, 4'b1111, 4'b1101, 4'b1110}, 1'b0);
      do_write({6'd0, 6'd0, 6'd4, 6'd2}, 4'b0000, 1'b1, 1'b1);
      wait_xfer();
      check_frame("minus", {6'd0, 6'd10, 6'd4, 6'd2}, {4'b1111, 4'b1011, 4'b1101, 4'b1110}, 1'b0);
      do_write({6'd0, 6'd0, 6'd0, 6'd5}, 4'b0010, 1'b0, 1'b1);
      wait_xfer();
      check_frame("dp", {6'd0, 6'd0, 6'd16, 6'd5}, {4'b1111, 4'b1111, 4'b1101, 4'b1110}, 1'b0);
      do_write({6'd1, 6'd2, 6'd3, 6'd4}, 4'b0000, 1'b1, 1'b1);
      wait_xfer();
      check_frame("ovf", {6'd10, 6'd2, 6'd3, 6'd4}, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 1'b1);
      wait_ft();
      @(posedge clk); #2;
      chk("hs_ready_a", wr_ready, 1);
      drive(1'b1, {6'd9, 6'd8, 6'd7, 6'd6}, 4'b0000, 1'b0, 1'b1);
      @(posedge clk); #2;
      drive(1'b1, {6'd3, 6'd3, 6'd3, 6'd3}, 4'b1111, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk("hs_busy", wr_ready, 0);
         @(posedge clk); #2;
      end
      wr_valid = 1'b0;
      wait_ft();
      chk("hs_ready_at_tick", wr_ready, 0);
      @(negedge clk);
      chk("hs_ready_after_tick", wr_ready, 1);
      check_frame("hs_a", {6'd9, 6'd8, 6'd7, 6'd6}, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 1'b0);
      @(posedge clk); #2;
      @(posedge clk); #2;
      drive(1'b1, {6'd0, 6'd0, 6'd0, 6'd0}, 4'b0000, 1'b1, 1'b1);
      @(negedge clk);
      chk("hs_tick_write_ft", frame_tick, 1);
      chk("hs_tick_write_rdy", wr_ready, 1);
      @(posedge clk); #2;
      wr_valid = 1'b0;
      @(negedge clk);
      chk("hs_held_pending", wr_ready, 0);
      check_frame("hs_still_a", {6'd9, 6'd8, 6'd7, 6'd6}, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 1'b0);
      wait_xfer();
      check_frame("hs_c", {6'd0, 6'd0, 6'd10, 6'd0}, {4'b1111, 4'b1111, 4'b1101, 4'b1110}, 1'b0);
      repeat (8) @(negedge clk);
      chk("pre_reset_sel", dig_sel, 4'b1110);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_sel", dig_sel, 4'b1111);
      chk("async_rst_num", num, 0);
      chk("async_rst_ready", wr_ready, 1);
      chk("async_rst_ovf", ovf, 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < SD * ND; i++) begin
         @(negedge clk);
         chk("post_rst_blank", dig_sel, 4'b1111);
      end
      for (int n = 0; n < 800; n++) begin
         @(posedge clk); #2;
         for (int i = 0; i < ND; i++) rc[6*i +: 6] = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom_range(0, 11));
         drive($urandom_range(0, 3) == 0, rc, 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      end
      wr_valid = 1'b0;
      repeat (3 * SD * ND) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
